// File: rtl/dmem_pkg.sv
// Shared definitions for the line-fill / write-back data memory responder.
//   state_e     : controller state encodings (2-bit)
//   LINE_WIDTH  : cache line width in bits
//   OFFSET_BITS : byte-offset bits inside a line (ignored by the responder)
//   CNT_WIDTH   : width of the latency down-counter
package dmem_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_WIDTH   = 8;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_WAIT = 2'd1,
    STATE_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_line_array.sv
// Line-wide single-port storage with registered read.
//   clk_i   : clock
//   rst_i   : async active-high reset (clears only the read register)
//   en_i    : access enable for this cycle
//   we_i    : 1 = write wdata_i to addr_i, 0 = read addr_i into rdata_o
//   addr_i  : line index
//   wdata_i : write line
//   rdata_o : last read line; holds across writes and idle cycles
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 9,
  parameter int DATA_W    = LINE_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o
);

  // Storage contents are deliberately left unreset.
  logic [DATA_W-1:0] mem_q [2**ADDR_BITS];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Responder end of the data cache line-fill / write-back interface. Accepts one
// line request, waits LATENCY edges, performs the access on the line array and
// pulses ack_o for one cycle.
//   clk_i    : clock
//   rst_i    : async active-high reset
//   enable_i : request valid (sampled only in IDLE)
//   write_i  : 1 = write line, 0 = read line
//   addr_i   : byte address; line index = addr_i[ADDR_BITS+4:5]
//   data_i   : write line data
//   ack_o    : one-cycle completion pulse
//   data_o   : read line data, valid with ack_o on reads, held otherwise
//
// state      | meaning
// IDLE       | waiting for enable_i; captures request on the first edge it is seen
// WAIT       | counting down the access latency; access done when counter is 0
// ACK        | ack_o high for this cycle; new requests ignored
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int ADDR_BITS  = 9,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  input  logic [31:0]           addr_i,
  input  logic [LINE_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [LINE_WIDTH-1:0] data_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

  state_e                  state_d, state_q;
  logic [CNT_WIDTH-1:0]    cnt_d, cnt_q;
  logic [ADDR_BITS-1:0]    idx_d, idx_q;
  logic                    write_d, write_q;
  logic [LINE_WIDTH-1:0]   wdata_d, wdata_q;
  logic                    ack_d, ack_q;
  logic                    access;

  // Offset and out-of-range address bits alias onto the index, by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:OFFSET_BITS+ADDR_BITS], addr_i[OFFSET_BITS-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    case (state_q)
      STATE_IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[OFFSET_BITS +: ADDR_BITS];
          write_d = write_i;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
          state_d = STATE_WAIT;
        end
      end
      STATE_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ack_d   = 1'b1;
          state_d = STATE_ACK;
        end
      end
      STATE_ACK: begin
        ack_d   = 1'b0;
        state_d = STATE_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  // The array access happens on the same edge that raises ack_q, so a read
  // result and the ack appear together. Reset drops state_q, which also
  // blocks an uncommitted write.
  assign access = (state_q == STATE_WAIT) && (cnt_q == '0);

  dmem_line_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (LINE_WIDTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (access),
    .we_i    (write_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

  assign ack_o = ack_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
module tb_dmem_line_responder;

  typedef struct {
    int           cyc;
    logic [255:0] data;
  } exp_t;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_DB = {8{32'hDEADBEEF}};
  localparam logic [255:0] PAT_1  = {8{32'h1111_2222}};
  localparam logic [255:0] PAT_2  = {8{32'h3333_4444}};
  localparam logic [255:0] PAT_3  = {8{32'h5555_6666}};
  localparam logic [255:0] PAT_5  = {8{32'h7777_8888}};
  localparam logic [255:0] PAT_6  = {8{32'h9999_AAAA}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en10 = 1'b0, wr10 = 1'b0, ack10;
  logic [31:0]  addr10 = '0;
  logic [255:0] din10 = '0, dout10;
  logic         en1 = 1'b0, wr1 = 1'b0, ack1;
  logic [31:0]  addr1 = '0;
  logic [255:0] din1 = '0, dout1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acks10 = 0;
  int acks1 = 0;
  exp_t q10[$];
  exp_t q1[$];
  logic [255:0] m10 [int];
  logic [255:0] m1 [int];
  logic [255:0] last10 = '0;
  logic [255:0] last1 = '0;

  dmem_line_responder #(.LATENCY(10), .ADDR_BITS(9), .LINE_WIDTH(256)) u_dut10 (
    .clk_i(clk), .rst_i(rst), .enable_i(en10), .write_i(wr10),
    .addr_i(addr10), .data_i(din10), .ack_o(ack10), .data_o(dout10)
  );

  dmem_line_responder #(.LATENCY(1), .ADDR_BITS(9), .LINE_WIDTH(256)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1),
    .addr_i(addr1), .data_i(din1), .ack_o(ack1), .data_o(dout1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int idx9(input logic [31:0] a);
    return int'(a[13:5]);
  endfunction

  task automatic chk_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic chk_line(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE (or in ACK with the
  // previous request's enable still held): capture happens on the next edge.
  task automatic go10(input logic w, input logic [31:0] a, input logic [255:0] d, input int cap_delay);
    exp_t e;
    en10 = 1'b1; wr10 = w; addr10 = a; din10 = d;
    e.cyc = cyc + cap_delay + 10;
    if (w) begin
      m10[idx9(a)] = d;
      e.data = last10;
    end else begin
      e.data = m10[idx9(a)];
      last10 = e.data;
    end
    q10.push_back(e);
  endtask

  task automatic go1(input logic w, input logic [31:0] a, input logic [255:0] d, input int cap_delay);
    exp_t e;
    en1 = 1'b1; wr1 = w; addr1 = a; din1 = d;
    e.cyc = cyc + cap_delay + 1;
    if (w) begin
      m1[idx9(a)] = d;
      e.data = last1;
    end else begin
      e.data = m1[idx9(a)];
      last1 = e.data;
    end
    q1.push_back(e);
  endtask

  // Returns #1 after the edge at which the cache samples ack_o.
  task automatic wait10();
    int n;
    n = acks10;
    for (int i = 0; i < 100 && acks10 == n; i++) @(posedge clk);
    checks++;
    if (acks10 == n) begin
      errors++;
      $display("FAIL ack10_timeout no ack within 100 cycles at cycle %0d", cyc);
    end
    #1;
  endtask

  task automatic wait1();
    int n;
    n = acks1;
    for (int i = 0; i < 100 && acks1 == n; i++) @(posedge clk);
    checks++;
    if (acks1 == n) begin
      errors++;
      $display("FAIL ack1_timeout no ack within 100 cycles at cycle %0d", cyc);
    end
    #1;
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (ack10 === 1'b1) begin
            acks10++;
            checks++;
            if (q10.size() == 0) begin
              errors++;
              $display("FAIL ack10_unexpected ack at cycle %0d data %h", cyc, dout10);
            end else begin
              e = q10.pop_front();
              if (cyc != e.cyc || dout10 !== e.data) begin
                errors++;
                $display("FAIL ack10 got cycle %0d data %h want cycle %0d data %h",
                         cyc, dout10, e.cyc, e.data);
              end
            end
          end
          if (ack1 === 1'b1) begin
            acks1++;
            checks++;
            if (q1.size() == 0) begin
              errors++;
              $display("FAIL ack1_unexpected ack at cycle %0d data %h", cyc, dout1);
            end else begin
              e = q1.pop_front();
              if (cyc != e.cyc || dout1 !== e.data) begin
                errors++;
                $display("FAIL ack1 got cycle %0d data %h want cycle %0d data %h",
                         cyc, dout1, e.cyc, e.data);
              end
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_ack10", ack10, 1'b0);
    chk_line("rst_data10", dout10, '0);
    chk_bit("rst_ack1", ack1, 1'b0);
    chk_line("rst_data1", dout1, '0);

    // LATENCY=1: request pending across reset release, captured on first edge.
    // 0x4020 aliases line 1 with 9 index bits; then read 0x20 with enable held.
    go1(1'b1, 32'h0000_4020, PAT_6, 1);
    #1 rst = 1'b0;
    wait1();
    go1(1'b0, 32'h0000_0020, '0, 1);
    wait1();
    en1 = 1'b0;

    // LATENCY=10, back-to-back requests (enable held between them).
    go10(1'b1, 32'h0000_0060, PAT_A5, 1);
    wait10();
    go10(1'b0, 32'h0000_0060, '0, 1);
    wait10();
    go10(1'b1, 32'h0000_0040, PAT_DB, 1);
    wait10();
    go10(1'b0, 32'h0000_0040, '0, 1);
    wait10();
    go10(1'b1, 32'h0000_2000, PAT_2, 1);
    wait10();
    go10(1'b1, 32'h0000_1000, PAT_1, 1);
    wait10();
    go10(1'b0, 32'h0000_2000, '0, 1);
    wait10();
    go10(1'b0, 32'h0000_1000, '0, 1);
    wait10();
    go10(1'b1, 32'h0000_0020, PAT_3, 1);
    wait10();

    // Inputs change mid-WAIT: request must finish as captured, no second one.
    go10(1'b0, 32'h0000_0020, '0, 1);
    repeat (4) @(posedge clk);
    #1;
    addr10 = 32'h0000_0040;
    wr10 = 1'b1;
    en10 = 1'b0;
    wait10();
    repeat (20) @(posedge clk);
    #1;

    // Reset in the middle of a write to line 5.
    go10(1'b1, 32'h0000_00A0, PAT_5, 1);
    wait10();
    en10 = 1'b1; wr10 = 1'b1; addr10 = 32'h0000_00A0; din10 = {255'b0, 1'b1};
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    en10 = 1'b0;
    #1;
    chk_bit("midrst_ack10", ack10, 1'b0);
    chk_line("midrst_data10", dout10, '0);
    chk_line("midrst_data1", dout1, '0);
    last10 = '0;
    last1 = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    go10(1'b0, 32'h0000_00A0, '0, 1);
    wait10();
    en10 = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q10.size() != 0) begin
      errors++;
      $display("FAIL q10_drain got %0d pending want 0", q10.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL q1_drain got %0d pending want 0", q1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
